// File: rtl/contador_min_hora.sv
// ============================================================================
//  Module   : contador_min_hora
//  Purpose  : Minutes/hours time-of-day counter driven by the seconds carry,
//             with a button-driven time-set mode and display blink phase.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_min_hora #(
    parameter int MIN_MAX   = 59,
    parameter int HOUR_MAX  = 23,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       modif_min,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] minutos,
    output logic [4:0] horas,
    output logic       modif_dia,
    output logic [1:0] set_mode,
    output logic       blink
);

    localparam int         c_CNT_W      = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [1:0] c_RUN        = 2'b00;
    localparam logic [1:0] c_SET_HOUR   = 2'b01;
    localparam logic [1:0] c_SET_MIN    = 2'b10;
    localparam logic [5:0] c_MIN_LAST   = 6'(MIN_MAX);
    localparam logic [4:0] c_HOUR_LAST  = 5'(HOUR_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLINK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [5:0]         r_min;
    logic [4:0]         r_hour;
    logic               r_modif_dia;
    logic               r_blink;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_prev_min;
    logic               r_prev_mode;
    logic               r_prev_inc;

    logic               w_ev_min;
    logic               w_ev_mode;
    logic               w_ev_inc;
    logic [1:0]         w_next_state;

    assign w_ev_min  = modif_min & ~r_prev_min;
    assign w_ev_mode = btn_mode  & ~r_prev_mode;
    assign w_ev_inc  = btn_inc   & ~r_prev_inc;

    always_comb begin
        w_next_state = c_RUN;
        case (r_state)
            c_RUN:      w_next_state = c_SET_HOUR;
            c_SET_HOUR: w_next_state = c_SET_MIN;
            default:    w_next_state = c_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_RUN;
            r_min       <= 6'd0;
            r_hour      <= 5'd0;
            r_modif_dia <= 1'b0;
            r_blink     <= 1'b0;
            r_cnt       <= '0;
            // Loading 1 hides a level that is already high at reset release
            r_prev_min  <= 1'b1;
            r_prev_mode <= 1'b1;
            r_prev_inc  <= 1'b1;
        end else begin
            r_prev_min  <= modif_min;
            r_prev_mode <= btn_mode;
            r_prev_inc  <= btn_inc;
            r_modif_dia <= 1'b0;

            // Carries arriving while setting are dropped, not queued
            if (r_state == c_RUN && w_ev_min) begin
                if (r_min >= c_MIN_LAST) begin
                    r_min <= 6'd0;
                    if (r_hour >= c_HOUR_LAST) begin
                        r_hour      <= 5'd0;
                        r_modif_dia <= 1'b1;
                    end else begin
                        r_hour <= r_hour + 5'd1;
                    end
                end else begin
                    r_min <= r_min + 6'd1;
                end
            end

            if (w_ev_inc && !w_ev_mode) begin
                if (r_state == c_SET_HOUR) begin
                    r_hour <= (r_hour >= c_HOUR_LAST) ? 5'd0 : r_hour + 5'd1;
                end else if (r_state == c_SET_MIN) begin
                    r_min <= (r_min >= c_MIN_LAST) ? 6'd0 : r_min + 6'd1;
                end
            end

            if (w_ev_mode) begin
                r_state <= w_next_state;
                r_cnt   <= '0;
                r_blink <= (w_next_state != c_RUN);
            end else if (r_state != c_SET_HOUR && r_state != c_SET_MIN) begin
                r_state <= c_RUN;
                r_cnt   <= '0;
                r_blink <= 1'b0;
            end else if (r_cnt >= c_CNT_LAST) begin
                r_cnt   <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign minutos   = r_min;
    assign horas     = r_hour;
    assign modif_dia = r_modif_dia;
    assign set_mode  = r_state;
    assign blink     = r_blink;

endmodule

`default_nettype wire

// File: tb/tb_contador_min_hora.sv
// ============================================================================
//  Module   : tb_contador_min_hora
//  Purpose  : Self-checking bench for contador_min_hora (vectors, corner
//             sequences and random stimulus against a minutes-of-day model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_contador_min_hora;

    localparam int BD = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       modif_min;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] minutos;
    logic [4:0] horas;
    logic       modif_dia;
    logic [1:0] set_mode;
    logic       blink;

    contador_min_hora #(
        .MIN_MAX   (59),
        .HOUR_MAX  (23),
        .BLINK_DIV (BD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .modif_min (modif_min),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .minutos   (minutos),
        .horas     (horas),
        .modif_dia (modif_dia),
        .set_mode  (set_mode),
        .blink     (blink)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time of day in minutes, mode index, cycles spent in mode
    int m_tod, m_mode, m_k;
    bit m_dia, p_mm, p_bm, p_bi;

    typedef struct {
        bit r, mm, bm, bi;
        int emin, ehr, edia, emode, eblink;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit mm, input bit bm, input bit bi);
        bit em, eb, ei;
        int nm;
        if (r) begin
            m_tod = 0; m_mode = 0; m_k = 0; m_dia = 0;
            p_mm = 1; p_bm = 1; p_bi = 1;
            return;
        end
        em = mm && !p_mm;
        eb = bm && !p_bm;
        ei = bi && !p_bi;
        p_mm = mm; p_bm = bm; p_bi = bi;
        m_dia = 0;
        nm = eb ? (m_mode + 1) % 3 : m_mode;
        if (m_mode == 0 && em) begin
            m_tod = (m_tod + 1) % 1440;
            if (m_tod == 0) m_dia = 1;
        end
        if (ei && !eb) begin
            if (m_mode == 1)
                m_tod = ((m_tod / 60 + 1) % 24) * 60 + m_tod % 60;
            else if (m_mode == 2)
                m_tod = (m_tod / 60) * 60 + (m_tod % 60 + 1) % 60;
        end
        m_k    = (nm != m_mode) ? 0 : m_k + 1;
        m_mode = nm;
    endtask

    task automatic tick(input bit r, input bit mm, input bit bm, input bit bi);
        reset = r; modif_min = mm; btn_mode = bm; btn_inc = bi;
        @(posedge clock);
        model_step(r, mm, bm, bi);
        #1;
        chk("model_minutos", int'(minutos), m_tod % 60);
        chk("model_horas", int'(horas), m_tod / 60);
        chk("model_modif_dia", int'(modif_dia), int'(m_dia));
        chk("model_set_mode", int'(set_mode), m_mode);
        chk("model_blink", int'(blink), (m_mode == 0) ? 0 : (((m_k / BD) % 2 == 0) ? 1 : 0));
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            tick(0, 0, 0, 1);
            tick(0, 0, 0, 0);
        end
    endtask

    task automatic press_mode();
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
    endtask

    task automatic set_time(input int h, input int m);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        press_mode();
        press_inc(h);
        press_mode();
        press_inc(m);
        press_mode();
    endtask

    initial begin
        int exp_h[3];
        reset = 1; modif_min = 0; btn_mode = 0; btn_inc = 0;

        //           r mm bm bi  min hr dia mode blink
        tbl[0]  = '{1, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 0,  1, 0, 0, 1, 1};
        tbl[7]  = '{0, 0, 0, 1,  1, 1, 0, 1, 1};
        tbl[8]  = '{0, 0, 0, 0,  1, 1, 0, 1, 1};
        tbl[9]  = '{0, 1, 0, 1,  1, 2, 0, 1, 1};
        tbl[10] = '{0, 0, 0, 0,  1, 2, 0, 1, 0};
        tbl[11] = '{0, 0, 1, 0,  1, 2, 0, 2, 1};
        tbl[12] = '{0, 0, 0, 1,  2, 2, 0, 2, 1};
        tbl[13] = '{0, 0, 0, 0,  2, 2, 0, 2, 1};
        tbl[14] = '{0, 0, 1, 1,  2, 2, 0, 0, 0};
        tbl[15] = '{0, 1, 0, 0,  3, 2, 0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].r, tbl[i].mm, tbl[i].bm, tbl[i].bi);
            chk($sformatf("vec%0d_min", i), int'(minutos), tbl[i].emin);
            chk($sformatf("vec%0d_hr", i), int'(horas), tbl[i].ehr);
            chk($sformatf("vec%0d_dia", i), int'(modif_dia), tbl[i].edia);
            chk($sformatf("vec%0d_mode", i), int'(set_mode), tbl[i].emode);
            chk($sformatf("vec%0d_blink", i), int'(blink), tbl[i].eblink);
        end

        // Day rollover from 23:59
        set_time(23, 59);
        chk("pre_2359_hr", int'(horas), 23);
        chk("pre_2359_min", int'(minutos), 59);
        tick(0, 1, 0, 0);
        chk("roll_min", int'(minutos), 0);
        chk("roll_hr", int'(horas), 0);
        chk("roll_dia", int'(modif_dia), 1);
        tick(0, 0, 0, 0);
        chk("roll_dia_after", int'(modif_dia), 0);
        tick(0, 0, 0, 0);
        chk("roll_dia_after2", int'(modif_dia), 0);

        // Held carry counts once
        set_time(10, 59);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0);
            chk("hold_hr", int'(horas), 11);
            chk("hold_min", int'(minutos), 0);
            chk("hold_dia", int'(modif_dia), 0);
        end
        tick(0, 0, 0, 0);

        // Hour and minute wrap in set mode
        set_time(22, 0);
        tick(0, 0, 1, 0);
        chk("enter_sethour_mode", int'(set_mode), 1);
        chk("enter_sethour_blink", int'(blink), 1);
        tick(0, 0, 0, 0);
        exp_h[0] = 23; exp_h[1] = 0; exp_h[2] = 1;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1);
            chk("sethour_hr", int'(horas), exp_h[i]);
            chk("sethour_min", int'(minutos), 0);
            tick(0, 0, 0, 0);
        end
        press_mode();
        chk("setmin_mode", int'(set_mode), 2);
        press_inc(61);
        chk("setmin_min", int'(minutos), 1);
        chk("setmin_hr", int'(horas), 1);
        tick(0, 1, 0, 0);
        chk("setmin_carry_ignored", int'(minutos), 1);
        tick(0, 0, 0, 0);

        // Reset aborts set mode
        set_time(7, 30);
        press_mode();
        chk("pre_reset_mode", int'(set_mode), 1);
        tick(1, 0, 0, 0);
        chk("rst_mode", int'(set_mode), 0);
        chk("rst_hr", int'(horas), 0);
        chk("rst_min", int'(minutos), 0);
        chk("rst_blink", int'(blink), 0);
        chk("rst_dia", int'(modif_dia), 0);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 299) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
